// File: rtl/md_unit.sv
// md_unit: multiply/divide sequencer for the execute stage. Owns the HI/LO registers.
//
// A start pulse in IDLE latches the operation and operands, then the unit stays busy for a
// fixed latency (MULT_CYCLES or DIV_CYCLES) before committing the 64-bit result to HI/LO.
// MTHI/MTLO writes are serviced while idle, and a flush aborts an in-flight operation
// without touching HI/LO.
//
// Ports:
//   clk      in   1   clock, all state updates on the rising edge
//   reset_n  in   1   synchronous active-low reset
//   start    in   1   E-stage mult/div instruction valid this cycle
//   op       in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a    in  32   rs operand (dividend / multiplicand)
//   src_b    in  32   rt operand (divisor / multiplier)
//   moveto   in   2   01 MTHI, 10 MTLO, 00/11 none
//   wdata    in  32   data for MTHI/MTLO
//   flush    in   1   cancel from the CP0 exception/eret path
//   busy     out  1   operation in flight (registered)
//   hi       out 32   HI register
//   lo       out 32   LO register
//
// Parameters (legal range 1..15, the counter is 4 bits wide):
//   MULT_CYCLES  busy cycles for MULT/MULTU
//   DIV_CYCLES   busy cycles for DIV/DIVU

module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  moveto,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;

  localparam logic [1:0] MoveHi = 2'b01;
  localparam logic [1:0] MoveLo = 2'b10;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // ---------------------------------------------------------------------------
  // Arithmetic on the latched operands
  // ---------------------------------------------------------------------------
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  logic               div_signed;
  logic               a_neg, b_neg;
  logic [31:0]        mag_a, mag_b, div_den;
  logic [31:0]        q_mag, r_mag;
  logic [31:0]        quot, rem;
  logic               div_by_zero;

  logic [31:0]        res_hi, res_lo;
  logic               res_write;

  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide is done on magnitudes and the signs are restored afterwards: the
    // quotient truncates toward zero and the remainder follows the dividend. This also
    // yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    div_signed  = ~op_q[0];
    a_neg       = div_signed & a_q[31];
    b_neg       = div_signed & b_q[31];
    mag_a       = a_neg ? (~a_q + 32'd1) : a_q;
    mag_b       = b_neg ? (~b_q + 32'd1) : b_q;
    div_by_zero = (b_q == 32'd0);
    // Keep the divider free of X when the divisor is zero; the result is discarded then.
    div_den     = div_by_zero ? 32'd1 : mag_b;
    q_mag       = mag_a / div_den;
    r_mag       = mag_a % div_den;
    quot        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem         = a_neg ? (~r_mag + 32'd1) : r_mag;

    res_write = 1'b1;
    unique case (op_q)
      OpMult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OpMultu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      default: begin
        res_hi    = rem;
        res_lo    = quot;
        res_write = ~div_by_zero;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer: next-state and HI/LO update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        // Priority: flush > start > moveto.
        if (flush) begin
          state_d = StIdle;
        end else if (start) begin
          op_d    = op;
          a_d     = src_a;
          b_d     = src_b;
          cnt_d   = op[1] ? DivCnt : MultCnt;
          state_d = StRun;
        end else begin
          if (moveto == MoveHi) begin
            hi_d = wdata;
          end else if (moveto == MoveLo) begin
            lo_d = wdata;
          end
        end
      end

      StRun: begin
        // start/moveto are deliberately not looked at here.
        if (flush) begin
          cnt_d   = 4'd0;
          state_d = StIdle;
        end else if (cnt_q == 4'd1) begin
          if (res_write) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
          cnt_d   = 4'd0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        cnt_d   = 4'd0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_q    <= 2'b00;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit. Each issued operation pushes its expected HI/LO and busy
// length into a scoreboard; a monitor pops and compares whenever busy falls.

module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [1:0]  moveto;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .moveto (moveto),
    .wdata  (wdata),
    .flush  (flush),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle T; returns in cycle T+1 with start released.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int len,
                          input string name);
    exp_t e;
    e.name = name;
    e.hi   = eh;
    e.lo   = el;
    e.len  = len;
    sb.push_back(e);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    check({name, " busy_at_T"}, {31'd0, busy}, 32'd0);
    tick();
    start  = 1'b0;
    moveto = 2'b00;
  endtask

  // Returns in the first cycle with busy low.
  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      tick();
    end
    if (busy === 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s wait_idle: busy still 1 after 40 cycles, expected 0", name);
    end
  endtask

  task automatic do_move(input logic [1:0] sel, input logic [31:0] d);
    moveto = sel;
    wdata  = d;
    tick();
    moveto = 2'b00;
  endtask

  // Monitor: measures each busy period and checks HI/LO in the cycle busy drops.
  initial begin
    int   run_len;
    logic prev_busy;
    exp_t e;
    run_len   = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        run_len++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL monitor: busy dropped after %0d cycles, expected no operation", run_len);
        end else begin
          e = sb.pop_front();
          check({e.name, " hi"}, hi, e.hi);
          check({e.name, " lo"}, lo, e.lo);
          check({e.name, " busy_len"}, 32'(run_len), 32'(e.len));
        end
        run_len = 0;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    src_a   = 32'd0;
    src_b   = 32'd0;
    moveto  = 2'b00;
    wdata   = 32'd0;
    flush   = 1'b0;
    repeat (2) tick();
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    tick();

    start_op(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult_neg2x3");
    wait_idle("mult_neg2x3");
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, "multu_max");
    wait_idle("multu_max");
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div_neg7_2");
    wait_idle("div_neg7_2");
    // Back-to-back in the cycle busy first drops; divide by zero leaves HI/LO alone.
    start_op(2'b11, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "divu_by_zero");
    wait_idle("divu_by_zero");

    do_move(2'b01, 32'h1234_5678);
    do_move(2'b10, 32'h9ABC_DEF0);
    check("mthi hi", hi, 32'h1234_5678);
    check("mtlo lo", lo, 32'h9ABC_DEF0);

    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, "div_overflow");
    wait_idle("div_overflow");
    start_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, "div_7_neg2");
    wait_idle("div_7_neg2");
    start_op(2'b11, 32'd100, 32'd7, 32'd2, 32'h0000_000E, 10, "divu_100_7");
    wait_idle("divu_100_7");

    // Flush in cycle T+3 of a MULT.
    start_op(2'b00, 32'd5, 32'd5, 32'd2, 32'h0000_000E, 3, "mult_flushed");
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy_T4", {31'd0, busy}, 32'd0);

    // Flush beats start and moveto in IDLE; moveto=11 is a no-op.
    flush = 1'b1;
    start = 1'b1;
    op    = 2'b00;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("flush_start busy", {31'd0, busy}, 32'd0);
    flush = 1'b1;
    do_move(2'b01, 32'hAAAA_AAAA);
    flush = 1'b0;
    check("flush_move hi", hi, 32'd2);
    do_move(2'b11, 32'h5555_5555);
    check("move11 hi", hi, 32'd2);
    check("move11 lo", lo, 32'h0000_000E);

    // start with moveto=01: the move is dropped.
    do_move(2'b01, 32'h1111_1111);
    moveto = 2'b01;
    wdata  = 32'hDEAD_BEEF;
    start_op(2'b00, 32'd6, 32'd7, 32'd0, 32'h0000_002A, 5, "mult_with_move");
    check("start_move hi_T1", hi, 32'h1111_1111);
    wait_idle("mult_with_move");

    // start and moveto pulsed while running are ignored.
    start_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5, "multu_run_noise");
    tick();
    start  = 1'b1;
    op     = 2'b10;
    src_a  = 32'd9;
    src_b  = 32'd0;
    moveto = 2'b10;
    wdata  = 32'hBADB_AD00;
    tick();
    start  = 1'b0;
    moveto = 2'b00;
    check("run_noise lo_T3", lo, 32'h0000_002A);
    check("run_noise busy_T3", {31'd0, busy}, 32'd1);
    wait_idle("multu_run_noise");

    // Reset in cycle T+2 of a DIV.
    do_move(2'b01, 32'hCAFE_F00D);
    check("mthi2 hi", hi, 32'hCAFE_F00D);
    start_op(2'b10, 32'd100, 32'd7, 32'd0, 32'd0, 2, "div_reset");
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_reset hi", hi, 32'd0);
    check("mid_reset lo", lo, 32'd0);
    check("mid_reset busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    check("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
